note_event_encoder: RTL and testbench

NOTE_EVENT_ENCODER -- requirements
Module: note_event_encoder

---
 rtl/note_event_encoder.sv | 112 +++++++++++
 tb/tb_note_event_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_event_encoder.sv
// rtl/note_event_encoder.sv - turns per-key gate changes into 3-byte MIDI note-on/off messages
// Lowest-index pending key wins; each event is latched and streamed with a valid/ready handshake.
module note_event_encoder #(
  parameter int         NUM_KEYS = 12,
  parameter logic [6:0] VEL_OFF  = 7'h00
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NUM_KEYS-1:0] gate_in,
  input  logic [3:0]          channel_in,
  input  logic [6:0]          base_note_in,
  input  logic [6:0]          velocity_in,
  output logic [7:0]          byte_out,
  output logic                byte_valid_out,
  input  logic                byte_ready_in,
  output logic                busy_out,
  output logic [15:0]         event_count_out
);

  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} state_t;

  state_t              state;
  logic [NUM_KEYS-1:0] reported;
  logic [NUM_KEYS-1:0] pending;
  logic [KW-1:0]       sel_idx;
  logic                sel_found;
  logic                sel_on;
  logic [7:0]          sel_note;
  logic [KW-1:0]       lat_key;
  logic                lat_on;
  logic [6:0]          lat_note;
  logic [6:0]          lat_vel;

  assign pending = gate_in ^ reported;

  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx   = KW'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign sel_on   = gate_in[sel_idx];
  assign sel_note = {1'b0, base_note_in} + 8'(sel_idx);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      reported        <= '0;
      byte_out        <= 8'h00;
      byte_valid_out  <= 1'b0;
      busy_out        <= 1'b0;
      event_count_out <= 16'h0000;
      lat_key         <= '0;
      lat_on          <= 1'b0;
      lat_note        <= 7'h00;
      lat_vel         <= 7'h00;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            if (sel_note[7]) begin
              // Note out of MIDI range: absorb the change silently.
              reported[sel_idx] <= sel_on;
            end else begin
              lat_key        <= sel_idx;
              lat_on         <= sel_on;
              lat_note       <= sel_note[6:0];
              lat_vel        <= !sel_on ? VEL_OFF :
                                (velocity_in == 7'd0) ? 7'd1 : velocity_in;
              byte_out       <= {(sel_on ? 4'h9 : 4'h8), channel_in};
              byte_valid_out <= 1'b1;
              busy_out       <= 1'b1;
              state          <= STATUS;
            end
          end
        end
        STATUS: begin
          if (byte_ready_in) begin
            byte_out <= {1'b0, lat_note};
            state    <= NOTE;
          end
        end
        NOTE: begin
          if (byte_ready_in) begin
            byte_out <= {1'b0, lat_vel};
            state    <= VEL;
          end
        end
        VEL: begin
          if (byte_ready_in) begin
            reported[lat_key] <= lat_on;
            event_count_out   <= event_count_out + 16'd1;
            byte_out          <= 8'h00;
            byte_valid_out    <= 1'b0;
            busy_out          <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_event_encoder.sv
// tb/tb_note_event_encoder.sv - self-checking bench for note_event_encoder
module tb_note_event_encoder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [11:0] gate_in = 12'h000;
  logic [3:0]  channel_in = 4'd0;
  logic [6:0]  base_note_in = 7'd60;
  logic [6:0]  velocity_in = 7'd100;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        byte_ready_in;
  logic        busy_out;
  logic [15:0] event_count_out;

  logic ready_force = 1'b1;
  logic rand_ready = 1'b0;
  logic rnd_bit = 1'b1;
  assign byte_ready_in = rand_ready ? rnd_bit : ready_force;

  note_event_encoder dut (
    .clk_in(clk_in), .rst_in(rst_in), .gate_in(gate_in), .channel_in(channel_in),
    .base_note_in(base_note_in), .velocity_in(velocity_in), .byte_out(byte_out),
    .byte_valid_out(byte_valid_out), .byte_ready_in(byte_ready_in),
    .busy_out(busy_out), .event_count_out(event_count_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;
  always @(posedge clk_in) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] cap_q[$];
  int         cap_cyc[$];
  logic [7:0] exp_q[$];
  logic [11:0] mrep;
  logic [15:0] mcount;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(byte_valid_out), 32'd1);
        check("hold_byte", 32'(byte_out), 32'(prev_byte));
      end
      check("valid_eq_busy", 32'(byte_valid_out), 32'(busy_out));
      if (byte_valid_out && byte_ready_in) begin
        cap_q.push_back(byte_out);
        cap_cyc.push_back(cyc);
      end
      prev_stall = byte_valid_out && !byte_ready_in;
      prev_byte  = byte_out;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 16 && n < 3000) begin
      @(negedge clk_in);
      n++;
      if (!busy_out && !byte_valid_out) q++;
      else q = 0;
    end
    if (q < 16) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_quiet: still busy after %0d cycles", n);
    end
    tick();
  endtask

  task automatic wait_valid(string name, logic [7:0] want);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!(byte_valid_out && byte_out == want) && n < 100);
    check(name, 32'(byte_out), 32'(want));
  endtask

  task automatic cmp_stream(string name);
    check({name, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (k < cap_q.size()) check($sformatf("%s_b%0d", name, k), 32'(cap_q[k]), 32'(exp_q[k]));
  endtask

  task automatic clear_q();
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  task automatic model_step(logic [11:0] g, logic [3:0] ch, logic [6:0] b, logic [6:0] vel);
    for (int i = 0; i < 12; i++) begin
      if (g[i] != mrep[i]) begin
        mrep[i] = g[i];
        if (int'(b) + i <= 127) begin
          exp_q.push_back({(g[i] ? 4'h9 : 4'h8), ch});
          exp_q.push_back(8'(int'(b) + i));
          exp_q.push_back(g[i] ? ((vel == 7'd0) ? 8'd1 : {1'b0, vel}) : 8'h00);
          mcount++;
        end
      end
    end
  endtask

  typedef struct {
    logic [11:0] gate;
    logic [3:0]  ch;
    logic [6:0]  base;
    logic [6:0]  vel;
    int          nbytes;
    logic [47:0] bytes;
    int          count;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{12'h001, 4'd0, 7'd60,  7'd100, 3, 48'h90_3C_64_00_00_00, 1};
    vecs[1] = '{12'h000, 4'd3, 7'd60,  7'd100, 3, 48'h83_3C_00_00_00_00, 2};
    vecs[2] = '{12'h00A, 4'd0, 7'd60,  7'd100, 6, 48'h90_3D_64_90_3F_64, 4};
    vecs[3] = '{12'h000, 4'd0, 7'd60,  7'd100, 6, 48'h80_3D_00_80_3F_00, 6};
    vecs[4] = '{12'h800, 4'd0, 7'd120, 7'd100, 0, 48'h0, 6};
    vecs[5] = '{12'h800, 4'd0, 7'd60,  7'd100, 0, 48'h0, 6};
    vecs[6] = '{12'h000, 4'd0, 7'd60,  7'd100, 3, 48'h80_47_00_00_00_00, 7};
    vecs[7] = '{12'h001, 4'd0, 7'd60,  7'd0,   3, 48'h90_3C_01_00_00_00, 8};
    vecs[8] = '{12'h000, 4'd0, 7'd60,  7'd100, 3, 48'h80_3C_00_00_00_00, 9};

    #1;
    check("rst_byte", 32'(byte_out), 32'h0);
    check("rst_valid", 32'(byte_valid_out), 32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_count", 32'(event_count_out), 32'h0);
    repeat (2) @(posedge clk_in);
    #3 rst_in = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      gate_in      = vecs[v].gate;
      channel_in   = vecs[v].ch;
      base_note_in = vecs[v].base;
      velocity_in  = vecs[v].vel;
      wait_quiet();
      for (int k = 0; k < vecs[v].nbytes; k++) exp_q.push_back(vecs[v].bytes[47 - 8 * k -: 8]);
      cmp_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d_count", v), 32'(event_count_out), 32'(vecs[v].count));
      for (int m = 0; m * 3 + 2 < cap_cyc.size(); m++) begin
        check("consecutive", 32'(cap_cyc[3 * m + 2] - cap_cyc[3 * m]), 32'd2);
        if (m > 0) check("spacing", 32'(cap_cyc[3 * m] - cap_cyc[3 * m - 3]), 32'd4);
      end
      clear_q();
    end

    // Backpressure on the NOTE byte for 5 cycles
    base_note_in = 7'd60; velocity_in = 7'd100; channel_in = 4'd0;
    ready_force = 1'b0;
    gate_in = 12'h001;
    wait_valid("bp_status", 8'h90);
    tick();
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check("bp_hold_byte", 32'(byte_out), 32'h3C);
      check("bp_hold_valid", 32'(byte_valid_out), 32'd1);
    end
    tick();
    ready_force = 1'b1;
    wait_quiet();
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    cmp_stream("bp");
    check("bp_count", 32'(event_count_out), 32'd10);
    clear_q();
    gate_in = 12'h000;
    wait_quiet();
    exp_q.push_back(8'h80); exp_q.push_back(8'h3C); exp_q.push_back(8'h00);
    cmp_stream("bp_rel");
    check("bp_rel_count", 32'(event_count_out), 32'd11);
    clear_q();

    // Key toggles and channel changes during its own message
    gate_in = 12'h001;
    wait_valid("tog_status", 8'h90);
    tick();
    gate_in = 12'h000;
    channel_in = 4'd5;
    wait_quiet();
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    exp_q.push_back(8'h85); exp_q.push_back(8'h3C); exp_q.push_back(8'h00);
    cmp_stream("tog");
    check("tog_count", 32'(event_count_out), 32'd13);
    clear_q();

    // Reset in NOTE state, key held through reset
    channel_in = 4'd0;
    gate_in = 12'h001;
    wait_valid("mid_note", 8'h3C);
    #2 rst_in = 1'b1;
    #1;
    check("mid_rst_valid", 32'(byte_valid_out), 32'd0);
    check("mid_rst_busy", 32'(busy_out), 32'd0);
    check("mid_rst_byte", 32'(byte_out), 32'd0);
    check("mid_rst_count", 32'(event_count_out), 32'd0);
    @(posedge clk_in);
    clear_q();
    #3 rst_in = 1'b0;
    wait_quiet();
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    cmp_stream("post_rst");
    check("post_rst_count", 32'(event_count_out), 32'd1);
    clear_q();

    // Randomized scans against the reference model with random backpressure
    mrep = 12'h001;
    mcount = 16'd1;
    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      gate_in      = 12'($urandom);
      channel_in   = 4'($urandom);
      base_note_in = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(100, 127)) : 7'($urandom);
      velocity_in  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
      model_step(gate_in, channel_in, base_note_in, velocity_in);
      wait_quiet();
      cmp_stream($sformatf("rand%0d", it));
      check($sformatf("rand%0d_count", it), 32'(event_count_out), 32'(mcount));
      clear_q();
    end
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
